// File: rtl/tube_write_arbiter_if.sv
// tube_write_arbiter_if: two requester ports plus the registered display-driver write bus
interface tube_write_arbiter_if;
  logic        req0, sel0, ack0;
  logic        req1, sel1, ack1;
  logic [31:0] wdata0, wdata1;
  logic        drv_we, busy, last_grant;
  logic [3:0]  drv_be;
  logic [31:0] drv_addr, drv_din;
  modport master (
    output req0, sel0, wdata0, req1, sel1, wdata1,
    input  ack0, ack1, drv_we, drv_be, drv_addr, drv_din, busy, last_grant
  );
  modport slave (
    input  req0, sel0, wdata0, req1, sel1, wdata1,
    output ack0, ack1, drv_we, drv_be, drv_addr, drv_din, busy, last_grant
  );
endinterface

// File: rtl/tube_write_arbiter.sv
// tube_write_arbiter: round-robin sharing of the 7-segment display registers with a post-write hold window
module tube_write_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7f38,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned HOLD_W      = 8
) (
  input logic clk,
  input logic reset,
  tube_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_e;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES == 0 ? 0 : HOLD_CYCLES - 1);
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d, gnt_q, gnt_d, last_q, last_d;
  logic              we_q, we_d, ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       addr_q, addr_d, din_q, din_d;
  logic              g, s;
  logic [31:0]       d;
  always_comb begin
    g = (bus.req0 & bus.req1) ? rr_q : bus.req1;
    s = g ? bus.sel1 : bus.sel0;
    d = g ? bus.wdata1 : bus.wdata0;
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    be_d    = be_q;
    addr_d  = addr_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE: if (bus.req0 | bus.req1) begin
        state_d = WRITE;
        gnt_d   = g;
        we_d    = 1'b1;
        ack0_d  = ~g;
        ack1_d  = g;
        be_d    = s ? 4'b0001 : 4'b1111;
        addr_d  = BASE_ADDR + {29'd0, s, 2'b00};
        din_d   = s ? {24'd0, d[7:0]} : d;
      end
      WRITE: begin
        last_d  = gnt_q;
        rr_d    = ~gnt_q;
        state_d = (HOLD_CYCLES == 0) ? IDLE : HOLD;
        cnt_d   = HOLD_LOAD;
      end
      HOLD: begin
        state_d = (cnt_q == '0) ? IDLE : HOLD;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - HOLD_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.drv_we     = we_q;
  assign bus.drv_be     = be_q;
  assign bus.drv_addr   = addr_q;
  assign bus.drv_din    = din_q;
  assign bus.busy       = busy_q;
  assign bus.last_grant = last_q;
endmodule

// File: tb/tb_tube_write_arbiter.sv
// tb_tube_write_arbiter: directed scenarios then random traffic, checked every cycle against a timestamp model
module tb_tube_write_arbiter;
  localparam logic [31:0] BASE = 32'h0000_7f38;
  localparam int H = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  tube_write_arbiter_if bus();
  tube_write_arbiter #(.BASE_ADDR(BASE), .HOLD_CYCLES(H), .HOLD_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, free_at = 0, wr_t = -1000;
  bit rr, cur_g, old_g;
  logic e_ack0, e_ack1, e_we, e_busy, e_last;
  logic [3:0] e_be;
  logic [31:0] e_addr, e_din;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Model: the arbiter is free to sample at cycle free_at; a grant at t writes at t+1 and frees at t+H+2.
  task automatic model();
    bit g, s;
    logic [31:0] d;
    e_ack0 = 0; e_ack1 = 0; e_we = 0;
    if (reset) begin
      free_at = cyc + 1; wr_t = -1000; rr = 0; cur_g = 0; old_g = 0;
      e_addr = 0; e_be = 0; e_din = 0; e_busy = 0; e_last = 0;
    end else begin
      if (cyc >= free_at && (bus.req0 || bus.req1)) begin
        g = (bus.req0 && bus.req1) ? rr : bus.req1;
        s = g ? bus.sel1 : bus.sel0;
        d = g ? bus.wdata1 : bus.wdata0;
        e_we = 1; e_ack0 = !g; e_ack1 = g;
        e_addr = BASE + (s ? 32'd4 : 32'd0);
        e_be = s ? 4'h1 : 4'hF;
        e_din = s ? (d & 32'hFF) : d;
        wr_t = cyc + 1; free_at = cyc + H + 2; rr = !g; old_g = cur_g; cur_g = g;
      end
      e_busy = (cyc + 1 >= wr_t) && (cyc + 1 < free_at);
      e_last = (cyc + 1 > wr_t) ? cur_g : old_g;
    end
  endtask
  task automatic step();
    model();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("ack0", bus.ack0, e_ack0);
    chk("ack1", bus.ack1, e_ack1);
    chk("drv_we", bus.drv_we, e_we);
    chk("busy", bus.busy, e_busy);
    chk("last_grant", bus.last_grant, e_last);
    chk("drv_be", bus.drv_be, e_be);
    chk("drv_addr", bus.drv_addr, e_addr);
    chk("drv_din", bus.drv_din, e_din);
  endtask
  task automatic wait_ack(input bit p, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      step();
      if (p ? bus.ack1 : bus.ack0) at = cyc;
    end
    checks++;
    assert (at >= 0) else begin
      errors++;
      $error("FAIL ack%0d_timeout: observed no ack expected one within %0d cycles", p, lim);
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 60 && bus.busy; i++) step();
    chk("idle_reached", bus.busy, 0);
  endtask
  initial begin
    int at, at2, prev, b;
    bit p;
    bus.req0 = 0; bus.sel0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.sel1 = 0; bus.wdata1 = 0;
    repeat (3) step();
    reset = 0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_we", bus.drv_we, 0);
    chk("rst_addr", bus.drv_addr, 0);
    bus.req0 = 1; bus.sel0 = 0; bus.wdata0 = 32'h1234_ABCD;
    step();
    bus.req0 = 0;
    chk("single_we", bus.drv_we, 1);
    chk("single_ack0", bus.ack0, 1);
    chk("single_addr", bus.drv_addr, 32'h7f38);
    chk("single_be", bus.drv_be, 4'hF);
    chk("single_din", bus.drv_din, 32'h1234_ABCD);
    b = 1;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      step();
      if (bus.busy) b++;
    end
    chk("busy_len", b, 17);
    reset = 1; step(); reset = 0;
    bus.req0 = 1; bus.wdata0 = $urandom; bus.req1 = 1; bus.wdata1 = $urandom;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      at = -1; p = 0;
      for (int i = 0; i < 40 && at < 0; i++) begin
        step();
        if (bus.ack0 || bus.ack1) begin at = cyc; p = bus.ack1; end
      end
      chk("rr_ack_seen", at >= 0, 1);
      chk("rr_order", p, k[0]);
      if (k > 0) chk("we_spacing", at - prev, H + 2);
      prev = at;
      if (p) bus.req1 = 0; else bus.req0 = 0;
      step();
      chk("rr_last_grant", bus.last_grant, p);
      bus.req0 = 1; bus.req1 = 1;
    end
    bus.req0 = 0; bus.req1 = 0;
    wait_idle();
    bus.req1 = 1; bus.sel1 = 1; bus.wdata1 = 32'hFFFF_FF5A;
    wait_ack(1, 40, at);
    bus.req1 = 0;
    chk("disp1_addr", bus.drv_addr, 32'h7f3c);
    chk("disp1_be", bus.drv_be, 4'b0001);
    chk("disp1_din", bus.drv_din, 32'h0000_005A);
    repeat (3) step();
    bus.req1 = 1; bus.sel1 = 0; bus.wdata1 = $urandom;
    wait_ack(1, 40, at2);
    bus.req1 = 0;
    chk("hold_wait", at2 - at, H + 2);
    wait_idle();
    reset = 1; bus.req0 = 1; bus.sel0 = 1; bus.wdata0 = $urandom;
    step();
    chk("rst_grant_we", bus.drv_we, 0);
    chk("rst_grant_ack", bus.ack0, 0);
    reset = 0;
    wait_ack(0, 10, at);
    bus.req0 = 0;
    repeat (3) step();
    reset = 1; step(); reset = 0;
    chk("rst_hold_busy", bus.busy, 0);
    chk("rst_hold_din", bus.drv_din, 0);
    repeat (4) step();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (bus.ack0) bus.req0 = 0;
      else if (!bus.req0 && $urandom_range(0, 3) == 0) begin
        bus.req0 = 1; bus.sel0 = 1'($urandom); bus.wdata0 = $urandom;
      end else if (bus.req0 && $urandom_range(0, 49) == 0) bus.req0 = 0;
      if (bus.ack1) bus.req1 = 0;
      else if (!bus.req1 && $urandom_range(0, 3) == 0) begin
        bus.req1 = 1; bus.sel1 = 1'($urandom); bus.wdata1 = $urandom;
      end else if (bus.req1 && $urandom_range(0, 49) == 0) bus.req1 = 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
